// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and the bitwise round helpers
// used by the streaming core and its compression-round sub-module.
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } state_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] ep0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] ep1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; a..h packed with a in [255:224].
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] i_vars,
  input  logic [31:0]  i_k,
  input  logic [31:0]  i_w,
  output logic [255:0] o_vars
);

  logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  logic [31:0] w_t1, w_t2;

  assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_vars;

  assign w_t1   = w_h + ep1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
  assign w_t2   = ep0(w_a) + maj(w_a, w_b, w_c);
  assign o_vars = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule

// File: rtl/sha256_stream_core.sv
// Streaming SHA-256 block engine: accepts one padded 512-bit block, runs RPC
// rounds per clock over a 16-word message window, then folds into H.
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int RPC      = 1,
  parameter bit OUT_HOLD = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic [511:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] data_out,
  output logic         busy
);

  localparam logic [5:0] LAST_T = 6'(64 - RPC);

  state_t        r_state, w_state_nxt;
  logic [5:0]    r_t;
  logic          r_first;
  logic [255:0]  r_h;
  logic [255:0]  r_vars;
  logic [31:0]   r_w [16];
  logic [31:0]   w_ext [16 + RPC];
  logic [255:0]  w_base;
  logic          w_accept;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    data_out    = OUT_HOLD ? r_h : '0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_nxt = ROUND;
      end
      ROUND:   if (r_t == LAST_T) w_state_nxt = FINAL;
      FINAL:   w_state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        data_out  = r_h;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = in_valid && in_ready;
  assign w_base   = r_first ? IV : r_h;

  // Window holds W[t..t+15]; extend it by RPC words to feed this cycle and refill.
  always_comb begin
    for (int i = 0; i < 16; i++) w_ext[i] = r_w[i];
    for (int i = 16; i < 16 + RPC; i++)
      w_ext[i] = sig1(w_ext[i-2]) + w_ext[i-7] + sig0(w_ext[i-15]) + w_ext[i-16];
  end

  for (genvar j = 0; j < RPC; j++) begin : g_round
    logic [255:0] w_in, w_out;
    if (j == 0) begin : g_head
      assign w_in = r_vars;
    end else begin : g_link
      assign w_in = g_round[j-1].w_out;
    end
    sha256_round u_round (
      .i_vars (w_in),
      .i_k    (K[r_t + 6'(j)]),
      .i_w    (w_ext[j]),
      .o_vars (w_out)
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_t     <= '0;
      r_first <= 1'b0;
      r_h     <= IV;
    end else begin
      if (w_accept) begin
        r_t     <= '0;
        r_first <= in_first;
      end else if (r_state == ROUND) begin
        r_t <= r_t + 6'(RPC);
      end
      if (r_state == FINAL)
        for (int i = 0; i < 8; i++)
          r_h[255-32*i -: 32] <= w_base[255-32*i -: 32] + r_vars[255-32*i -: 32];
    end
  end

  // NOTE: the working variables and message window are fully reloaded on accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_vars <= in_first ? IV : r_h;
      for (int i = 0; i < 16; i++) r_w[i] <= data_in[511-32*i -: 32];
    end else if (r_state == ROUND) begin
      r_vars <= g_round[RPC-1].w_out;
      for (int i = 0; i < 16; i++) r_w[i] <= w_ext[i+RPC];
    end
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Directed bench: three cores (RPC 1/2/4, last one with OUT_HOLD=0) share
// stimulus and are checked against published SHA-256 digests.
module tb_sha256_stream_core;

  localparam logic [255:0] TB_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_BLK1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_first, out_ready;
  logic [511:0] data_in;
  logic         ir [3];
  logic         ov [3];
  logic         bz [3];
  logic [255:0] dout [3];
  int           checks   = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  sha256_stream_core #(.RPC(1), .OUT_HOLD(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_first(in_first),
    .data_in(data_in), .out_valid(ov[0]), .out_ready(out_ready), .data_out(dout[0]), .busy(bz[0]));
  sha256_stream_core #(.RPC(2), .OUT_HOLD(1'b1)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_first(in_first),
    .data_in(data_in), .out_valid(ov[1]), .out_ready(out_ready), .data_out(dout[1]), .busy(bz[1]));
  sha256_stream_core #(.RPC(4), .OUT_HOLD(1'b0)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .in_first(in_first),
    .data_in(data_in), .out_valid(ov[2]), .out_ready(out_ready), .data_out(dout[2]), .busy(bz[2]));

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (n < 300 && !(ir[0] && ir[1] && ir[2])) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 256'(ir[0] && ir[1] && ir[2]), 256'(1'b1));
  endtask

  // Counts negedges after the accepting edge until out_valid is seen.
  task automatic watch(input int d, input int lat, input logic [255:0] dig,
                       input bit chk_dig, input string tag);
    int n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (ov[d]) break;
    end
    check($sformatf("%s_u%0d_lat", tag, d), 256'(n), 256'(lat));
    if (chk_dig) check($sformatf("%s_u%0d_digest", tag, d), dout[d], dig);
  endtask

  task automatic submit(input logic first, input logic [511:0] blk, input logic [255:0] dig,
                        input bit chk_dig, input string tag);
    wait_idle(tag);
    in_valid = 1'b1;
    in_first = first;
    data_in  = blk;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = ~first;
    data_in  = '1;
    fork
      watch(0, 66, dig, chk_dig, tag);
      watch(1, 34, dig, chk_dig, tag);
      watch(2, 18, dig, chk_dig, tag);
    join
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] held;
    int           bad;
    int           ov_seen;
    int           n;

    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; data_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 256'(ir[0]), 256'(1'b1));
    check("rst_out_valid", 256'(ov[0]), 256'(1'b0));
    check("rst_busy", 256'(bz[0]), 256'(1'b0));
    check("rst_dout_hold1", dout[0], TB_IV);
    check("rst_dout_hold0", dout[2], '0);

    submit(1'b1, ABC_BLK, ABC_DIG, 1'b1, "abc");
    @(negedge clk);
    check("idle_hold1", dout[0], ABC_DIG);
    check("idle_hold0", dout[2], '0);
    check("idle_out_valid", 256'(ov[0]), 256'(1'b0));

    submit(1'b1, EMPTY_BLK, EMPTY_DIG, 1'b1, "empty");
    submit(1'b1, TWO_BLK1, '0, 1'b0, "two_b1");
    submit(1'b0, TWO_BLK2, TWO_DIG, 1'b1, "two_b2");

    // Backpressure: consumer stalls 20 cycles while a new block is offered.
    wait_idle("bp");
    in_valid = 1'b1; in_first = 1'b1; data_in = ABC_BLK; out_ready = 1'b0;
    @(posedge clk);
    #1;
    n = 0;
    while (n < 200 && !ov[0]) begin
      @(negedge clk);
      n++;
    end
    check("bp_lat", 256'(n), 256'(66));
    held = dout[0];
    check("bp_digest", held, ABC_DIG);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dout[0] !== held || ir[0] !== 1'b0 || ov[0] !== 1'b1 || bz[0] !== 1'b1) bad++;
    end
    check("bp_stall_stable", 256'(bad), '0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ready", 256'(ir[0]), 256'(1'b1));
    check("bp_release_busy", 256'(bz[0]), 256'(1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_reaccept_busy", 256'(bz[0]), 256'(1'b1));
    n = 0;
    while (n < 200 && !ov[0]) begin
      @(negedge clk);
      n++;
    end
    check("bp_second_digest", dout[0], ABC_DIG);

    // Abort mid-ROUND, then chain "abc" with in_first=0 from the restored IV.
    wait_idle("abort");
    in_valid = 1'b1; in_first = 1'b1; data_in = EMPTY_BLK;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ov_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (ov[0]) ov_seen++;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("abort_h_iv", dout[0], TB_IV);
    check("abort_busy", 256'(bz[0]), 256'(1'b0));
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (ov[0]) ov_seen++;
    end
    check("abort_no_digest", 256'(ov_seen), '0);
    submit(1'b0, ABC_BLK, ABC_DIG, 1'b1, "abc_after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_stream_core.md
SHA256_STREAM_CORE -- requirements
Module: sha256_stream_core

Interface
REQ-001 Parameter RPC, default 1: SHA-256 rounds per clock; legal values 1, 2, 4 (64 % RPC == 0).
REQ-002 Parameter OUT_HOLD, default 1: 1 holds digest on data_out while idle; 0 drives zero when out_valid is low.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  message block offered.
REQ-006 in_ready  output  1  core can accept a block.
REQ-007 in_first  input  1  1 = first block of message (chain from IV); 0 = continue from stored hash.
REQ-008 data_in  input  512  padded block; data_in[511:480] = W0 (big-endian word order).
REQ-009 out_valid  output  1  digest valid.
REQ-010 out_ready  input  1  consumer accepts digest.
REQ-011 data_out  output  256  hash state; data_out[255:224] = H0 ... [31:0] = H7.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states: IDLE, ROUND, FINAL, DONE; reset enters IDLE.
REQ-014 in_ready = 1 only in IDLE; a block is accepted on an edge with in_valid && in_ready; in_first and data_in are sampled only on that edge.
REQ-015 On accept: W window (16 x 32) loaded from data_in; working vars a..h loaded from IV if in_first = 1, else from stored H; round counter cleared; go to ROUND.
REQ-016 ROUND: each cycle applies RPC consecutive rounds t..t+RPC-1 using K[t] and W[t]; W[t] for t >= 16 = sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16] mod 2^32 via a 16-word sliding window (no 64-word store).
REQ-017 After 64/RPC ROUND cycles go to FINAL; FINAL does H[i] <= H[i] + var[i] mod 2^32 for all eight words (IV used as base when in_first was 1), then go to DONE.
REQ-018 DONE: out_valid = 1, data_out = H; stays until out_ready = 1, then IDLE on that edge; data_out stable while out_valid && !out_ready.
REQ-019 Latency: out_valid first high 64/RPC + 2 edges after the accepting edge (66/34/18 for RPC 1/2/4).
REQ-020 Throughput with out_ready tied high: one block per 64/RPC + 3 cycles.
REQ-021 in_valid while busy: ignored, no state change; the offered block stays pending for the source.
REQ-022 First block after reset with in_first = 0: chains from IV (H reset value).
REQ-023 All additions are modulo 2^32; no carry leaves a word.

Reset
REQ-024 Reset clears FSM to IDLE, round counter to 0, out_valid to 0, busy to 0, and in_ready to 1 on the following cycle.
REQ-025 Reset loads H to IV (6a09e667 ... 5be0cd19); data_out = IV if OUT_HOLD = 1, else 0.
REQ-026 Reset mid-ROUND/FINAL/DONE aborts the block; no digest is produced and H returns to IV.

Structure
REQ-027 Package sha256_pkg holds the K[0:63] table, the IV constant, the state enum, and functions rotr, ch, maj, ep0, ep1, sig0, sig1.
REQ-028 Sub-module sha256_round: one combinational compression round (in: a..h, K, W; out: next a..h); the core instantiates RPC instances chained in series.

Verification
REQ-029 "abc" single padded block, in_first = 1, RPC = 1 -> out_valid at edge 66; data_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-030 Empty message block, in_first = 1 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-031 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first = 1, then 0) -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-032 Repeat REQ-029 at RPC = 2 and 4 -> identical digest; out_valid at edges 34 and 18.
REQ-033 out_ready held low 20 cycles in DONE with in_valid high -> data_out stable, in_ready = 0, no second accept until out_ready pulses.
REQ-034 Reset asserted at ROUND cycle 30, then "abc" with in_first = 0 -> no out_valid from the aborted block; digest equals REQ-029.
